// File: rtl/bin_to_bcd_serial_if.sv
// Request/result bundle between the binary counter and the BCD converter.
// The master drives start/bin_in; the converter (slave) returns digits and flags.
interface bin_to_bcd_serial_if #(
    parameter int unsigned BIN_WIDTH = 14,
    parameter int unsigned DIGITS    = 4
);
    logic                  start;
    logic [BIN_WIDTH-1:0]  bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [DIGITS-1:0]     blank;
    logic                  overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, blank, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, blank, overflow
    );
endinterface

// File: rtl/bin_to_bcd_serial.sv
// Iterative shift-and-add-3 binary to packed BCD converter with leading-zero
// blank flags; results are registered and held between conversions.
module bin_to_bcd_serial #(
    parameter int unsigned BIN_WIDTH = 14,
    parameter int unsigned DIGITS    = 4
) (
    input  logic                   clk,
    input  logic                   user_btn,
    bin_to_bcd_serial_if.slave     io
);
    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned CNT_W   = $clog2(BIN_WIDTH);
    localparam int unsigned MAX_VAL = (10 ** DIGITS) - 1;

    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};
    localparam logic [BCD_W-1:0]  ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIN_WIDTH-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]      scr_q, scr_d;
    logic                  cap_ovf_q, cap_ovf_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic [DIGITS-1:0]     blank_q, blank_d;
    logic                  overflow_q, overflow_d;

    logic [BCD_W-1:0]      adj_c;
    logic [DIGITS-1:0]     blank_c;

    // Add-3 correction applied to every scratch digit before each shift.
    always_comb begin
        adj_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            adj_c[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3
                                                        : scr_q[4*i +: 4];
        end
    end

    // Leading-zero flags; the ones digit is never blanked.
    always_comb begin
        logic lead;
        lead    = 1'b1;
        blank_c = '0;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            lead       = lead & (scr_q[4*i +: 4] == 4'd0);
            blank_c[i] = lead;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        cap_ovf_d  = cap_ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (io.start) begin
                    bin_d     = io.bin_in;
                    scr_d     = '0;
                    cnt_d     = '0;
                    cap_ovf_d = 32'(io.bin_in) > MAX_VAL;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Out-of-range values skip the iterations entirely.
                if (cap_ovf_q) begin
                    state_d = FINISH;
                end else begin
                    {scr_d, bin_d} = {adj_c[BCD_W-2:0], bin_q, 1'b0};
                    cnt_d          = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
                if (cap_ovf_q) begin
                    bcd_d      = ALL_NINES;
                    blank_d    = '0;
                    overflow_d = 1'b1;
                end else begin
                    bcd_d      = scr_q;
                    blank_d    = blank_c;
                    overflow_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge user_btn) begin
        if (!user_btn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            scr_q      <= '0;
            cap_ovf_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            blank_q    <= BLANK_RST;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            cap_ovf_q  <= cap_ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
            overflow_q <= overflow_d;
        end
    end

    assign io.busy     = busy_q;
    assign io.done     = done_q;
    assign io.bcd_out  = bcd_q;
    assign io.blank    = blank_q;
    assign io.overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Directed bench for bin_to_bcd_serial: hand-computed BCD results, latency,
// leading-zero flags, overflow, ignored starts, mid-conversion reset, streaming.
module tb_bin_to_bcd_serial;
    localparam int unsigned BIN_WIDTH = 14;
    localparam int unsigned DIGITS    = 4;

    logic clk = 1'b0;
    logic user_btn;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    bin_to_bcd_serial_if #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_serial #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .user_btn (user_btn),
        .io       (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  32'(bus.busy),     32'h0);
        check({tag, "_done"},  32'(bus.done),     32'h0);
        check({tag, "_bcd"},   32'(bus.bcd_out),  32'h0000);
        check({tag, "_blank"}, 32'(bus.blank),    32'he);
        check({tag, "_ovf"},   32'(bus.overflow), 32'h0);
    endtask

    task automatic convert(input string tag, input logic [13:0] val, input logic [15:0] exp_bcd,
                           input logic [3:0] exp_blank, input logic exp_ovf, input int exp_lat);
        int cyc;
        bit seen;
        bit busy_ok;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = val;
        tick();
        bus.start = 1'b0;
        cyc     = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && cyc < 40) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            tick();
            cyc++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check({tag, "_done"},    32'(seen),         32'h1);
        check({tag, "_lat"},     32'(cyc),          32'(exp_lat));
        check({tag, "_busyrun"}, 32'(busy_ok),      32'h1);
        check({tag, "_busydn"},  32'(bus.busy),     32'h0);
        check({tag, "_bcd"},     32'(bus.bcd_out),  32'(exp_bcd));
        check({tag, "_blank"},   32'(bus.blank),    32'(exp_blank));
        check({tag, "_ovf"},     32'(bus.overflow), 32'(exp_ovf));
        tick();
        check({tag, "_pulse"},   32'(bus.done),     32'h0);
        check({tag, "_hold"},    32'(bus.bcd_out),  32'(exp_bcd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ndone;
        int cyc;
        bit seen;

        user_btn   = 1'b0;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        tick();
        tick();
        check_reset_vals("rst");
        @(negedge clk);
        user_btn = 1'b1;
        repeat (3) tick();
        check_reset_vals("idle_hold");

        convert("c1234",  14'd1234,  16'h1234, 4'b0000, 1'b0, 15);
        convert("c7",     14'd7,     16'h0007, 4'b1110, 1'b0, 15);
        convert("c0",     14'd0,     16'h0000, 4'b1110, 1'b0, 15);
        convert("c40",    14'd40,    16'h0040, 4'b1100, 1'b0, 15);
        convert("c9999",  14'd9999,  16'h9999, 4'b0000, 1'b0, 15);
        convert("c10000", 14'd10000, 16'h9999, 4'b0000, 1'b1, 2);
        convert("c305",   14'd305,   16'h0305, 4'b1000, 1'b0, 15);
        convert("c16383", 14'd16383, 16'h9999, 4'b0000, 1'b1, 2);
        convert("c8",     14'd8,     16'h0008, 4'b1110, 1'b0, 15);

        // Start and bin_in changes while busy must be ignored.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 14'd1234;
        tick();
        bus.start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                bus.start  = 1'b1;
                bus.bin_in = 14'd42;
            end else if (c == 6) begin
                bus.start  = 1'b0;
                bus.bin_in = 14'd77;
            end
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        check("ign_ndone", 32'(ndone),       32'd1);
        check("ign_bcd",   32'(bus.bcd_out), 32'h1234);
        check("ign_blank", 32'(bus.blank),   32'h0);

        // Reset at cycle 7 aborts the conversion without a done pulse.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 14'd4321;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        user_btn = 1'b0;
        #1;
        check_reset_vals("midrst");
        ndone = 0;
        repeat (20) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        check("midrst_nodone", 32'(ndone), 32'd0);
        @(negedge clk);
        user_btn = 1'b1;
        tick();
        check_reset_vals("midrst_rel");
        convert("c56", 14'd56, 16'h0056, 4'b1100, 1'b0, 15);

        // Continuous start: one result every BIN_WIDTH+2 cycles.
        @(negedge clk);
        bus.bin_in = 14'd100;
        bus.start  = 1'b1;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check("cont_first", 32'(seen), 32'h1);
        for (int k = 0; k < 2; k++) begin
            seen = 1'b0;
            cyc  = 0;
            while (!seen && cyc < 40) begin
                tick();
                cyc++;
                if (bus.done === 1'b1) seen = 1'b1;
            end
            check("cont_period", 32'(cyc),         32'd16);
            check("cont_bcd",    32'(bus.bcd_out), 32'h0100);
            check("cont_blank",  32'(bus.blank),   32'h8);
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) tick();
        check("drain_busy", 32'(bus.busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
